// File: rtl/seq_mult_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier: one SLICE x SLICE multiplier
// walked over every slice pair, shift-accumulated into a 2*WIDTH register.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one partial product per cycle, k = 0 .. NS*NS-1
// DONE  | product valid for this single cycle
// ERR   | protocol violation seen; a start restarts like IDLE
module seq_mult_ctrl #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4,
  localparam int NS   = WIDTH / SLICE,
  localparam int SELW = $clog2(NS)
) (
  input  logic               clk,
  input  logic               reset_a,
  input  logic               start,
  input  logic [WIDTH-1:0]   dataa,
  input  logic [WIDTH-1:0]   datab,
  output logic [2*WIDTH-1:0] product,
  output logic               done,
  output logic               busy,
  output logic               err,
  output logic [SELW-1:0]    a_sel,
  output logic [SELW-1:0]    b_sel,
  output logic [2:0]         state_out
);

  localparam int KW = $clog2(NS * NS);
  localparam logic [KW-1:0] K_LAST = KW'(NS * NS - 1);
  localparam logic [KW-1:0] NS_K   = KW'(NS);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE, S_ERR} state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;

  logic [KW-1:0]        a_idx, b_idx;
  logic [31:0]          a_pos, b_pos;
  logic [WIDTH-1:0]     a_shr, b_shr;
  logic [2*SLICE-1:0]   pp;
  logic [2*WIDTH-1:0]   pp_shift;

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  // Slice-pair partial product, aligned to its weight in the accumulator.
  always_comb begin
    a_idx    = k_q % NS_K;
    b_idx    = k_q / NS_K;
    a_pos    = 32'(a_idx) * SLICE;
    b_pos    = 32'(b_idx) * SLICE;
    a_shr    = a_q >> a_pos;
    b_shr    = b_q >> b_pos;
    pp       = {{SLICE{1'b0}}, a_shr[SLICE-1:0]} * {{SLICE{1'b0}}, b_shr[SLICE-1:0]};
    pp_shift = {{(2*WIDTH-2*SLICE){1'b0}}, pp} << (a_pos + b_pos);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          a_d     = dataa;
          b_d     = datab;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (start) begin
          state_d = S_ERR;
        end else begin
          acc_d = acc_q + pp_shift;
          if (k_q == K_LAST) state_d = S_DONE;
          else               k_d     = k_q + 1'b1;
        end
      end
      S_DONE:  state_d = start ? S_ERR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    product   = acc_q;
    done      = (state_q == S_DONE);
    busy      = (state_q == S_CALC);
    err       = (state_q == S_ERR);
    a_sel     = '0;
    b_sel     = '0;
    state_out = 3'd0;
    unique case (state_q)
      S_IDLE: state_out = 3'd0;
      S_CALC: begin
        a_sel = a_idx[SELW-1:0];
        b_sel = b_idx[SELW-1:0];
        if (k_q == '0)          state_out = 3'd1;
        else if (k_q == K_LAST) state_out = 3'd3;
        else                    state_out = 3'd2;
      end
      S_DONE:  state_out = 3'd4;
      S_ERR:   state_out = 3'd5;
      default: state_out = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl: an 8-bit/4-bit instance and a
// 16-bit/4-bit instance, compared against plain multiplication and cycle counts.
module tb_seq_mult_ctrl;

  logic        clk;
  logic        reset_a;
  logic        start;
  logic [7:0]  dataa, datab;
  logic [15:0] product;
  logic        done, busy, err;
  logic [0:0]  a_sel, b_sel;
  logic [2:0]  state_out;

  logic        start16;
  logic [15:0] da16, db16;
  logic [31:0] p16;
  logic        done16, busy16, err16;
  logic [1:0]  as16, bs16;
  logic [2:0]  so16;

  int pass_cnt = 0;
  int total_cnt = 0;

  seq_mult_ctrl #(.WIDTH(8), .SLICE(4)) dut (
    .clk(clk), .reset_a(reset_a), .start(start), .dataa(dataa), .datab(datab),
    .product(product), .done(done), .busy(busy), .err(err),
    .a_sel(a_sel), .b_sel(b_sel), .state_out(state_out)
  );

  seq_mult_ctrl #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .reset_a(reset_a), .start(start16), .dataa(da16), .datab(db16),
    .product(p16), .done(done16), .busy(busy16), .err(err16),
    .a_sel(as16), .b_sel(bs16), .state_out(so16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_a = 1'b1; start = 1'b0; start16 = 1'b0;
    dataa = 8'h0; datab = 8'h0; da16 = 16'h0; db16 = 16'h0;
    #2;
    step; step;
    total_cnt++; if (product !== 16'h0) $display("FAIL reset_product got %h exp 0000", product); else pass_cnt++;
    total_cnt++; if ({done, busy, err} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {done, busy, err}); else pass_cnt++;
    total_cnt++; if ({a_sel, b_sel} !== 2'b00) $display("FAIL reset_sel got %b exp 00", {a_sel, b_sel}); else pass_cnt++;
    total_cnt++; if (state_out !== 3'd0) $display("FAIL reset_state got %0d exp 0", state_out); else pass_cnt++;
    total_cnt++; if (p16 !== 32'h0 || so16 !== 3'd0) $display("FAIL reset_wide got %h/%0d exp 0/0", p16, so16); else pass_cnt++;
    reset_a = 1'b0;
    step;
    total_cnt++; if (state_out !== 3'd0) $display("FAIL idle_after_reset got %0d exp 0", state_out); else pass_cnt++;
  endtask

  // Directed operands first (0xFF*0xFF, 0x0D*0xB7, corners), then random ones.
  task automatic test_ops;
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [15:0] exp_p;
    logic [2:0]  exp_so;
    qa = '{8'hFF, 8'h0D, 8'h00, 8'hFF, 8'h80, 8'h01};
    qb = '{8'hFF, 8'hB7, 8'hAB, 8'h00, 8'h02, 8'h01};
    for (int r = 0; r < 14; r++) begin
      qa.push_back(8'($urandom));
      qb.push_back(8'($urandom));
    end
    for (int n = 0; n < qa.size(); n++) begin
      exp_p = {8'h00, qa[n]} * {8'h00, qb[n]};
      dataa = qa[n]; datab = qb[n]; start = 1'b1;
      step;
      start = 1'b0;
      dataa = 8'($urandom); datab = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
        exp_so = (k == 0) ? 3'd1 : (k == 3) ? 3'd3 : 3'd2;
        total_cnt++; if (state_out !== exp_so) $display("FAIL ops_state op%0d k%0d got %0d exp %0d", n, k, state_out, exp_so); else pass_cnt++;
        total_cnt++; if (a_sel !== 1'(k % 2) || b_sel !== 1'(k / 2)) $display("FAIL ops_sel op%0d k%0d got (%0d,%0d) exp (%0d,%0d)", n, k, a_sel, b_sel, k % 2, k / 2); else pass_cnt++;
        total_cnt++; if ({done, busy, err} !== 3'b010) $display("FAIL ops_calc_flags op%0d k%0d got %b exp 010", n, k, {done, busy, err}); else pass_cnt++;
        step;
      end
      total_cnt++; if (done !== 1'b1 || state_out !== 3'd4) $display("FAIL ops_done op%0d got done=%b state=%0d exp 1/4", n, done, state_out); else pass_cnt++;
      total_cnt++; if (product !== exp_p) $display("FAIL ops_product op%0d %h*%h got %h exp %h", n, qa[n], qb[n], product, exp_p); else pass_cnt++;
      step;
      total_cnt++; if (done !== 1'b0 || state_out !== 3'd0) $display("FAIL ops_idle op%0d got done=%b state=%0d exp 0/0", n, done, state_out); else pass_cnt++;
      total_cnt++; if (product !== exp_p) $display("FAIL ops_hold op%0d got %h exp %h", n, product, exp_p); else pass_cnt++;
    end
  endtask

  task automatic test_start_held;
    dataa = 8'h5A; datab = 8'hC3; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step;
      if (i % 2 == 0) begin
        total_cnt++; if (state_out !== 3'd1 || err !== 1'b0 || busy !== 1'b1) $display("FAIL held_calc cyc%0d got state=%0d err=%b busy=%b exp 1/0/1", i, state_out, err, busy); else pass_cnt++;
      end else begin
        total_cnt++; if (state_out !== 3'd5 || err !== 1'b1 || busy !== 1'b0) $display("FAIL held_err cyc%0d got state=%0d err=%b busy=%b exp 5/1/0", i, state_out, err, busy); else pass_cnt++;
      end
      total_cnt++; if (done !== 1'b0) $display("FAIL held_done cyc%0d got %b exp 0", i, done); else pass_cnt++;
    end
    start = 1'b0;
    step;
    total_cnt++; if (state_out !== 3'd5) $display("FAIL held_stay_err got %0d exp 5", state_out); else pass_cnt++;
  endtask

  // Abort in the 2nd CALC cycle: only the (0,0) partial 0xB*0xD = 0x8F is in acc.
  task automatic test_err_calc;
    dataa = 8'hAB; datab = 8'hCD; start = 1'b1;
    step;
    start = 1'b0;
    step;
    start = 1'b1;
    step;
    start = 1'b0;
    total_cnt++; if (err !== 1'b1 || state_out !== 3'd5 || done !== 1'b0) $display("FAIL errcalc_enter got err=%b state=%0d done=%b exp 1/5/0", err, state_out, done); else pass_cnt++;
    total_cnt++; if (product !== 16'h008F) $display("FAIL errcalc_partial got %h exp 008f", product); else pass_cnt++;
    step; step;
    total_cnt++; if (err !== 1'b1 || done !== 1'b0 || product !== 16'h008F) $display("FAIL errcalc_stay got err=%b done=%b prod=%h exp 1/0/008f", err, done, product); else pass_cnt++;
    dataa = 8'h12; datab = 8'h34; start = 1'b1;
    step;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL errcalc_restart k%0d got done=%b busy=%b exp 0/1", k, done, busy); else pass_cnt++;
      step;
    end
    total_cnt++; if (done !== 1'b1 || product !== 16'h03A8) $display("FAIL errcalc_result got done=%b prod=%h exp 1/03a8", done, product); else pass_cnt++;
    step;
  endtask

  task automatic test_err_done;
    dataa = 8'h21; datab = 8'h03; start = 1'b1;
    step;
    start = 1'b0;
    step; step; step; step;
    total_cnt++; if (done !== 1'b1 || product !== 16'h0063) $display("FAIL errdone_done got done=%b prod=%h exp 1/0063", done, product); else pass_cnt++;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (err !== 1'b1 || state_out !== 3'd5 || done !== 1'b0) $display("FAIL errdone_err cyc%0d got err=%b state=%0d done=%b exp 1/5/0", i, err, state_out, done); else pass_cnt++;
      total_cnt++; if (product !== 16'h0063) $display("FAIL errdone_hold cyc%0d got %h exp 0063", i, product); else pass_cnt++;
      step;
    end
  endtask

  task automatic test_reset_mid;
    dataa = 8'h77; datab = 8'h99; start = 1'b1;
    step;
    start = 1'b0;
    step; step;
    total_cnt++; if (state_out !== 3'd2 || busy !== 1'b1) $display("FAIL rstmid_pre got state=%0d busy=%b exp 2/1", state_out, busy); else pass_cnt++;
    #2 reset_a = 1'b1;
    #1;
    total_cnt++; if (product !== 16'h0 || state_out !== 3'd0) $display("FAIL rstmid_async got prod=%h state=%0d exp 0000/0", product, state_out); else pass_cnt++;
    total_cnt++; if ({done, busy, err, a_sel, b_sel} !== 5'b0) $display("FAIL rstmid_flags got %b exp 00000", {done, busy, err, a_sel, b_sel}); else pass_cnt++;
    #2 reset_a = 1'b0;
    step;
    total_cnt++; if (done !== 1'b0 || state_out !== 3'd0) $display("FAIL rstmid_nodone got done=%b state=%0d exp 0/0", done, state_out); else pass_cnt++;
    dataa = 8'h03; datab = 8'h05; start = 1'b1;
    step;
    start = 1'b0;
    step; step; step; step;
    total_cnt++; if (done !== 1'b1 || product !== 16'h000F) $display("FAIL rstmid_after got done=%b prod=%h exp 1/000f", done, product); else pass_cnt++;
    step;
  endtask

  task automatic test_wide;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [31:0] exp_p;
    logic [2:0]  exp_so;
    qa = '{16'hFFFF, 16'h1234};
    qb = '{16'hFFFF, 16'hABCD};
    for (int r = 0; r < 3; r++) begin
      qa.push_back(16'($urandom));
      qb.push_back(16'($urandom));
    end
    for (int n = 0; n < qa.size(); n++) begin
      exp_p = {16'h0, qa[n]} * {16'h0, qb[n]};
      da16 = qa[n]; db16 = qb[n]; start16 = 1'b1;
      step;
      start16 = 1'b0;
      da16 = 16'($urandom); db16 = 16'($urandom);
      for (int k = 0; k < 16; k++) begin
        exp_so = (k == 0) ? 3'd1 : (k == 15) ? 3'd3 : 3'd2;
        total_cnt++; if (so16 !== exp_so || done16 !== 1'b0) $display("FAIL wide_state op%0d k%0d got %0d/%b exp %0d/0", n, k, so16, done16, exp_so); else pass_cnt++;
        total_cnt++; if (as16 !== 2'(k % 4) || bs16 !== 2'(k / 4)) $display("FAIL wide_sel op%0d k%0d got (%0d,%0d) exp (%0d,%0d)", n, k, as16, bs16, k % 4, k / 4); else pass_cnt++;
        step;
      end
      total_cnt++; if (done16 !== 1'b1 || so16 !== 3'd4) $display("FAIL wide_done op%0d got done=%b state=%0d exp 1/4", n, done16, so16); else pass_cnt++;
      total_cnt++; if (p16 !== exp_p) $display("FAIL wide_product op%0d %h*%h got %h exp %h", n, qa[n], qb[n], p16, exp_p); else pass_cnt++;
      step;
      total_cnt++; if (so16 !== 3'd0 || done16 !== 1'b0) $display("FAIL wide_idle op%0d got state=%0d done=%b exp 0/0", n, so16, done16); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_ops;
    test_start_held;
    test_err_calc;
    test_err_done;
    test_reset_mid;
    test_wide;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
